// File: rtl/cprv_wb_stage.sv
// -----------------------------------------------------------------------------
// cprv_wb_stage
//   Writeback stage of the cprv64g pipeline, fed by the mem stage.
//   Accepts one instruction per valid/ready handshake and picks the result:
//   the ALU output, or load data. Load data is byte-aligned and then sign- or
//   zero-extended here. The result is held in an output register that drives
//   the register-file write port, which is also the forwarding source. The
//   stage also keeps the retired-instruction counter (instret).
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   valid_wb_i        mem stage presents an instruction
//   ready_wb_o        this stage accepts an instruction this cycle
//   rd_addr_wb_i      destination register
//   rd_en_wb_i        the instruction writes rd
//   opcode_wb_i       RV opcode (7'b0000011 = LOAD)
//   funct3_wb_i       load width / signedness
//   alu_out_wb_i      ALU result; effective address for loads
//   mem_data_wb_i     aligned doubleword read from dmem
//   rf_valid_o        write record valid (forwarding valid)
//   rf_ready_i        register-file write port accepts the record
//   rf_we_o           write enable: rd_en, rd != x0 and record valid
//   rf_waddr_o        write address
//   rf_wdata_o        write data
//   instret_clr_i     synchronous clear of instret
//   instret_o         retired-instruction count
// -----------------------------------------------------------------------------
module cprv_wb_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_wb_i,
   output logic                  ready_wb_o,
   input  logic [4:0]            rd_addr_wb_i,
   input  logic                  rd_en_wb_i,
   input  logic [6:0]            opcode_wb_i,
   input  logic [2:0]            funct3_wb_i,
   input  logic [DATA_WIDTH-1:0] alu_out_wb_i,
   input  logic [DATA_WIDTH-1:0] mem_data_wb_i,
   output logic                  rf_valid_o,
   input  logic                  rf_ready_i,
   output logic                  rf_we_o,
   output logic [4:0]            rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   input  logic                  instret_clr_i,
   output logic [CNT_WIDTH-1:0]  instret_o
);

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   logic                  rf_valid_q, rf_valid_d;
   logic                  rf_we_q,    rf_we_d;
   logic [4:0]            rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic [CNT_WIDTH-1:0]  instret_q,  instret_d;

   logic                  xfer;
   logic [DATA_WIDTH-1:0] load_shifted;
   logic [DATA_WIDTH-1:0] result;

   // The output register can take a new record when it is empty or is being
   // drained this cycle. ready does not depend on valid_wb_i. It is held low
   // while reset is asserted.
   assign ready_wb_o = rst_n & (~rf_valid_q | rf_ready_i);
   assign xfer       = valid_wb_i & ready_wb_o;

   // Move the addressed byte to bit 0. Bytes shifted in from above bit 63 are
   // zero, so a misaligned access simply reads zeros.
   assign load_shifted = mem_data_wb_i >> {alu_out_wb_i[2:0], 3'b000};

   always_comb begin
      result = alu_out_wb_i;
      if (opcode_wb_i == OPC_LOAD) begin
         case (funct3_wb_i)
            3'b000:  result = {{(DATA_WIDTH-8){load_shifted[7]}},   load_shifted[7:0]};
            3'b001:  result = {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  result = {{(DATA_WIDTH-32){load_shifted[31]}}, load_shifted[31:0]};
            3'b011:  result = load_shifted;
            3'b100:  result = {{(DATA_WIDTH-8){1'b0}},  load_shifted[7:0]};
            3'b101:  result = {{(DATA_WIDTH-16){1'b0}}, load_shifted[15:0]};
            3'b110:  result = {{(DATA_WIDTH-32){1'b0}}, load_shifted[31:0]};
            default: result = '0;   // reserved encoding
         endcase
      end
   end

   always_comb begin
      rf_valid_d = rf_valid_q;
      rf_we_d    = rf_we_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      instret_d  = instret_q;

      if (xfer) begin
         rf_valid_d = 1'b1;
         rf_we_d    = rd_en_wb_i & (rd_addr_wb_i != 5'd0);
         rf_waddr_d = rd_addr_wb_i;
         rf_wdata_d = result;
      end else if (rf_ready_i) begin
         // Record consumed. Address and data stay put; rf_we_o is masked by
         // rf_valid_o.
         rf_valid_d = 1'b0;
      end

      // A clear wins over a retire in the same cycle.
      if (instret_clr_i) begin
         instret_d = '0;
      end else if (xfer) begin
         instret_d = instret_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_valid_q <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         instret_q  <= '0;
      end else begin
         rf_valid_q <= rf_valid_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         instret_q  <= instret_d;
      end
   end

   assign rf_valid_o = rf_valid_q;
   assign rf_we_o    = rf_we_q & rf_valid_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign instret_o  = instret_q;

endmodule

// File: tb/tb_cprv_wb_stage.sv
module tb_cprv_wb_stage;

   localparam logic [6:0] LOAD = 7'b0000011;
   localparam logic [6:0] OPI  = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_wb_i = 1'b0;
   logic        ready_wb_o;
   logic [4:0]  rd_addr_wb_i = '0;
   logic        rd_en_wb_i = 1'b0;
   logic [6:0]  opcode_wb_i = '0;
   logic [2:0]  funct3_wb_i = '0;
   logic [63:0] alu_out_wb_i = '0;
   logic [63:0] mem_data_wb_i = '0;
   logic        rf_valid_o;
   logic        rf_ready_i = 1'b0;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [63:0] rf_wdata_o;
   logic        instret_clr_i = 1'b0;
   logic [63:0] instret_o;

   // Second instance with a 4-bit counter so that counter wrap is reached quickly.
   logic        ready_s, rf_valid_s, rf_we_s;
   logic [4:0]  rf_waddr_s;
   logic [63:0] rf_wdata_s;
   logic [3:0]  instret_s;

   always #5 clk = ~clk;

   cprv_wb_stage #(.DATA_WIDTH(64), .CNT_WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .valid_wb_i(valid_wb_i), .ready_wb_o(ready_wb_o),
      .rd_addr_wb_i(rd_addr_wb_i), .rd_en_wb_i(rd_en_wb_i), .opcode_wb_i(opcode_wb_i),
      .funct3_wb_i(funct3_wb_i), .alu_out_wb_i(alu_out_wb_i), .mem_data_wb_i(mem_data_wb_i),
      .rf_valid_o(rf_valid_o), .rf_ready_i(rf_ready_i), .rf_we_o(rf_we_o),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .instret_clr_i(instret_clr_i),
      .instret_o(instret_o));

   cprv_wb_stage #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_w4 (
      .clk(clk), .rst_n(rst_n), .valid_wb_i(valid_wb_i), .ready_wb_o(ready_s),
      .rd_addr_wb_i(rd_addr_wb_i), .rd_en_wb_i(rd_en_wb_i), .opcode_wb_i(opcode_wb_i),
      .funct3_wb_i(funct3_wb_i), .alu_out_wb_i(alu_out_wb_i), .mem_data_wb_i(mem_data_wb_i),
      .rf_valid_o(rf_valid_s), .rf_ready_i(rf_ready_i), .rf_we_o(rf_we_s),
      .rf_waddr_o(rf_waddr_s), .rf_wdata_o(rf_wdata_s), .instret_clr_i(instret_clr_i),
      .instret_o(instret_s));

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [63:0] wdata;
   } rec_t;

   rec_t        sb_q[$];
   int          n_total = 0;
   int          n_pass  = 0;
   bit          mon_en  = 1'b0;
   bit          valid_model = 1'b0, valid_pend = 1'b0;
   logic [63:0] cnt_model = '0, cnt_pend = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
   endtask

   // Reference load/ALU result built byte by byte from the ISA definition.
   function automatic logic [63:0] ref_wdata(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [63:0] alu, input logic [63:0] mem);
      logic [63:0] v;
      int nbytes;
      int off;
      v = '0;
      if (op != LOAD) return alu;
      if (f3 == 3'b111) return '0;
      nbytes = 1 << f3[1:0];
      off = int'(alu[2:0]);
      for (int i = 0; i < nbytes; i++)
         if (off + i < 8) v[8*i +: 8] = mem[8*(off+i) +: 8];
      if (!f3[2] && nbytes < 8 && v[8*nbytes-1])
         for (int b = 8*nbytes; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   // One cycle of stimulus. Inputs are driven on the falling edge. If a
   // handshake will happen on the next rising edge, the expected record is
   // queued.
   task automatic drive(input bit v, input logic [4:0] rd, input bit en, input logic [6:0] op,
                        input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] mem,
                        input bit rr, input bit clr, input bit has_exp, input logic [63:0] exp_w);
      bit   xfer;
      rec_t r;
      @(negedge clk);
      valid_model = valid_pend;
      cnt_model   = cnt_pend;
      valid_wb_i = v; rd_addr_wb_i = rd; rd_en_wb_i = en; opcode_wb_i = op;
      funct3_wb_i = f3; alu_out_wb_i = alu; mem_data_wb_i = mem;
      rf_ready_i = rr; instret_clr_i = clr;
      #1;
      xfer = v && (!valid_model || rr);
      if (xfer) begin
         r.we    = en && (rd != 5'd0);
         r.waddr = rd;
         r.wdata = has_exp ? exp_w : ref_wdata(op, f3, alu, mem);
         sb_q.push_back(r);
         $display("txn rd=%0d en=%0d op=%h f3=%0d alu=%h mem=%h -> wdata=%h",
                  rd, en, op, f3, alu, mem, r.wdata);
      end
      valid_pend = xfer ? 1'b1 : (rr ? 1'b0 : valid_model);
      cnt_pend   = clr ? 64'd0 : cnt_model + 64'(xfer);
   endtask

   task automatic idle(input bit rr);
      drive(1'b0, 5'd0, 1'b0, OPI, 3'd0, 64'd0, 64'd0, rr, 1'b0, 1'b0, 64'd0);
   endtask

   // Monitor: checks the output record against the scoreboard every cycle
   // and pops an entry when the register file takes it.
   always begin
      @(negedge clk);
      #2;
      if (mon_en) begin
         chk("ready", 64'(ready_wb_o), 64'(!valid_model || rf_ready_i));
         chk("ready_w4", 64'(ready_s), 64'(!valid_model || rf_ready_i));
         chk("rf_valid", 64'(rf_valid_o), 64'(valid_model));
         chk("rf_valid_w4", 64'(rf_valid_s), 64'(valid_model));
         chk("instret", instret_o, cnt_model);
         chk("instret_w4", 64'(instret_s), 64'(cnt_model[3:0]));
         if (valid_model) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 64'(rf_valid_o), 64'd0);
            end else begin
               chk("rf_we", 64'(rf_we_o), 64'(sb_q[0].we));
               chk("rf_waddr", 64'(rf_waddr_o), 64'(sb_q[0].waddr));
               chk("rf_wdata", rf_wdata_o, sb_q[0].wdata);
               if (rf_ready_i) void'(sb_q.pop_front());
            end
         end else begin
            chk("rf_we_idle", 64'(rf_we_o), 64'd0);
         end
      end
   end

   initial begin
      // Reset state
      #2;
      chk("rst_valid", 64'(rf_valid_o), 64'd0);
      chk("rst_we", 64'(rf_we_o), 64'd0);
      chk("rst_waddr", 64'(rf_waddr_o), 64'd0);
      chk("rst_wdata", rf_wdata_o, 64'd0);
      chk("rst_instret", instret_o, 64'd0);
      chk("rst_ready", 64'(ready_wb_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // ALU result
      drive(1, 5'd5, 1, OPI, 3'd0, 64'h1234, 64'hdead, 1, 0, 1, 64'h1234);
      idle(1);
      // Load extension
      drive(1, 5'd3, 1, LOAD, 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF80);
      drive(1, 5'd3, 1, LOAD, 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 1, 0, 1, 64'h80);
      drive(1, 5'd4, 1, LOAD, 3'b010, 64'h2004, 64'h8765_4321_0000_0000, 1, 0, 1, 64'hFFFF_FFFF_8765_4321);
      drive(1, 5'd4, 1, LOAD, 3'b110, 64'h2004, 64'h8765_4321_0000_0000, 1, 0, 1, 64'h8765_4321);
      drive(1, 5'd6, 1, LOAD, 3'b011, 64'h3005, 64'h1122_3344_5566_7788, 1, 0, 1, 64'h0000_0000_0011_2233);
      drive(1, 5'd6, 1, LOAD, 3'b001, 64'h3006, 64'h8001_3344_5566_7788, 1, 0, 1, 64'hFFFF_FFFF_FFFF_8001);
      drive(1, 5'd7, 1, LOAD, 3'b111, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 64'd0);
      idle(1);
      // Back-pressure: three stalled cycles, then back-to-back transfers.
      drive(1, 5'd9, 1, OPI, 3'd0, 64'h99, 64'd0, 1, 0, 1, 64'h99);
      for (int i = 0; i < 3; i++) drive(1, 5'd10, 1, OPI, 3'd0, 64'hA0, 64'd0, 0, 0, 1, 64'hA0);
      for (int i = 0; i < 4; i++) drive(1, 5'(11 + i), 1, OPI, 3'd0, 64'(i), 64'd0, 1, 0, 1, 64'(i));
      // x0 destination and a write-disabled instruction are still retired.
      drive(1, 5'd0, 1, OPI, 3'd0, 64'hAAAA, 64'd0, 1, 0, 1, 64'hAAAA);
      drive(1, 5'd8, 0, OPI, 3'd0, 64'hBBBB, 64'd0, 1, 0, 1, 64'hBBBB);
      // A clear together with a retire: that retire is not counted.
      drive(1, 5'd8, 1, OPI, 3'd0, 64'hCCCC, 64'd0, 1, 1, 1, 64'hCCCC);
      // 20 retires, enough to wrap the 4-bit counter.
      for (int i = 0; i < 20; i++) drive(1, 5'd1, 1, OPI, 3'd0, 64'(i), 64'd0, 1, 0, 0, 64'd0);
      idle(1);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom),
               ($urandom_range(0, 1) != 0) ? LOAD : 7'($urandom), 3'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom},
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), 0, 64'd0);
      end
      idle(1);

      // Reset while a record is held under back-pressure.
      drive(1, 5'd12, 1, OPI, 3'd0, 64'h5555, 64'd0, 1, 0, 1, 64'h5555);
      @(negedge clk);
      mon_en = 1'b0;
      valid_wb_i = 1'b0;
      rf_ready_i = 1'b0;
      instret_clr_i = 1'b0;
      #1;
      chk("pre_rst_valid", 64'(rf_valid_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(rf_valid_o), 64'd0);
      chk("mid_rst_we", 64'(rf_we_o), 64'd0);
      chk("mid_rst_instret", instret_o, 64'd0);
      chk("mid_rst_ready", 64'(ready_wb_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      valid_model = 1'b0; valid_pend = 1'b0;
      cnt_model = '0; cnt_pend = '0;
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) drive(1, 5'(20 + i), 1, OPI, 3'd0, 64'(100 + i), 64'd0, 1, 0, 1, 64'(100 + i));
      idle(1);
      idle(1);
      @(negedge clk);
      #3;
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
